// File: rtl/qam_pkg.sv
// Shared types and constants for the QAM sample upsampler.
// Holds the I/Q widths, the read-FSM state encoding and a constant clog2 helper.
package qam_pkg;

  localparam int IQ_W   = 16;
  localparam int DATA_W = 2 * IQ_W;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Elaboration-time ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/qam_sample_upsampler_if.sv
// Symbol-in / sample-out stream bundle of the upsampler, plus flag control and FIFO occupancy.
// The slave modport is the upsampler side; the master modport is the modulator/consumer side.
interface qam_sample_upsampler_if #(
  parameter int DATA_W     = qam_pkg::DATA_W,
  parameter int FIFO_DEPTH = 16
);
  import qam_pkg::clog2;

  localparam int LVL_W = clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] sym_in;
  logic              sym_valid;
  logic              sym_ready;
  logic [DATA_W-1:0] sample_out;
  logic              sample_valid;
  logic              sample_ready;
  logic              clr_flags;
  logic              overflow;
  logic              underflow;
  logic [LVL_W-1:0]  fill_level;

  modport master (
    output sym_in, sym_valid, sample_ready, clr_flags,
    input  sym_ready, sample_out, sample_valid, overflow, underflow, fill_level
  );

  modport slave (
    input  sym_in, sym_valid, sample_ready, clr_flags,
    output sym_ready, sample_out, sample_valid, overflow, underflow, fill_level
  );

endinterface

// File: rtl/qam_sym_fifo.sv
// Single-clock symbol FIFO with extra-MSB pointers for full/empty.
// ready_o is registered (not full next cycle) and is held low while rst is asserted.
module qam_sym_fifo
  import qam_pkg::clog2;
#(
  parameter int DATA_W = qam_pkg::DATA_W,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     ready_o,
  output logic                     empty_o,
  output logic [clog2(DEPTH):0]    level_o
);

  localparam int AW = clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              ready_q;
  logic              full_d;
  logic              push_ok;
  logic              pop_ok;

  // A push is only honoured when ready was already high, so a pop in the
  // same cycle cannot make room for a symbol offered while full.
  assign push_ok = push_i & ready_q;
  assign pop_ok  = pop_i & ~empty_o;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign level_o   = wr_ptr_q - rd_ptr_q;
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
  assign ready_o   = ready_q;

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
               (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= ~full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/qam_sample_upsampler.sv
// Buffers mapped {I,Q} symbols and replays each one as SPS output samples on a ready/valid stream.
// ZERO_STUFF selects zero-order hold or symbol-on-phase-0 with zeros elsewhere.
module qam_sample_upsampler #(
  parameter int DATA_W     = qam_pkg::DATA_W,
  parameter int SPS        = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int ZERO_STUFF = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  qam_sample_upsampler_if.slave bus
);
  import qam_pkg::state_e;
  import qam_pkg::IDLE;
  import qam_pkg::EMIT;
  import qam_pkg::clog2;

  localparam int              PH_W    = clog2(SPS);
  localparam int              LVL_W   = clog2(FIFO_DEPTH) + 1;
  localparam logic [PH_W-1:0] LAST_PH = PH_W'(SPS - 1);

  state_e            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              overflow_q;
  logic              underflow_q;
  logic              underflow_set;
  logic              overflow_set;
  logic              pop;
  logic              emit;

  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_ready;
  logic              fifo_empty;
  logic [LVL_W-1:0]  fifo_level;

  qam_sym_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (bus.sym_valid),
    .wr_data_i (bus.sym_in),
    .pop_i     (pop),
    .rd_data_o (fifo_rd_data),
    .ready_o   (fifo_ready),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level)
  );

  assign bus.sym_ready  = fifo_ready;
  assign bus.fill_level = fifo_level;
  assign bus.overflow   = overflow_q;
  assign bus.underflow  = underflow_q;

  assign emit             = (state_q == EMIT);
  assign bus.sample_valid = emit;
  assign overflow_set     = bus.sym_valid & ~fifo_ready;

  generate
    if (ZERO_STUFF != 0) begin : g_zero_stuff
      assign bus.sample_out = (emit && phase_q == '0) ? hold_q : '0;
    end else begin : g_zoh
      assign bus.sample_out = emit ? hold_q : '0;
    end
  endgenerate

  // Next symbol is fetched on the last accepted phase so symbols stream without a bubble.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    hold_d        = hold_q;
    pop           = 1'b0;
    underflow_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          hold_d  = fifo_rd_data;
          phase_d = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (bus.sample_ready) begin
          if (phase_q == LAST_PH) begin
            phase_d = '0;
            if (!fifo_empty) begin
              pop    = 1'b1;
              hold_d = fifo_rd_data;
            end else begin
              state_d       = IDLE;
              underflow_set = 1'b1;
            end
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      hold_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      hold_q      <= hold_d;
      // A new event outranks a clear arriving in the same cycle.
      overflow_q  <= overflow_set  | (overflow_q  & ~bus.clr_flags);
      underflow_q <= underflow_set | (underflow_q & ~bus.clr_flags);
    end
  end

endmodule

// File: doc/qam_sample_upsampler.md
Name: qam_sample_upsampler

Overview:
Downstream stage of the QAM modulator top. It accepts mapped 32-bit symbols ({I[15:0], Q[15:0]}) one per valid pulse and buffers them in a small FIFO. Each symbol is emitted as SPS output samples on a ready/valid stream toward the pulse-shaping filter / DAC interface. This decouples the modulator's bursty symbol rate from the constant sample-rate consumer.

Parameters:
DATA_W, 32, symbol/sample width ({I,Q}).
SPS, 8, samples per symbol, legal range 2..256.
FIFO_DEPTH, 16, symbol FIFO entries, power of 2, minimum 4.
ZERO_STUFF, 0, 0 = zero-order hold (repeat symbol); 1 = symbol on phase 0, zeros on other phases.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
sym_in  in  DATA_W  mapped symbol from modulator
sym_valid  in  1  sym_in valid this cycle
sym_ready  out  1  FIFO can accept (not full)
sample_out  out  DATA_W  output sample
sample_valid  out  1  sample_out valid
sample_ready  in  1  consumer accepts sample this cycle
clr_flags  in  1  clears sticky flags
overflow  out  1  sticky: symbol offered while full
underflow  out  1  sticky: stream starved mid-burst
fill_level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset values:
  - sym_ready=0 during rst, 1 on the first cycle after rst.
  - sample_valid=0, sample_out=0, overflow=0, underflow=0, fill_level=0.
  - FSM=IDLE, phase=0, FIFO pointers cleared.
  - rst mid-burst discards all buffered symbols and the hold register.
- Write side:
  - Push when sym_valid && sym_ready.
  - sym_ready = !full, registered from pointer state.
  - sym_valid while full: symbol dropped, overflow set the next cycle.
- Read FSM states: IDLE, EMIT.
  - IDLE: if FIFO not empty, pop into hold register, phase<=0, go to EMIT. Otherwise stay; sample_valid=0.
  - EMIT: sample_valid=1.
    - sample_out = hold when phase==0 or ZERO_STUFF=0; otherwise 0.
    - Phase advances only on sample_ready. sample_out is held stable while !sample_ready.
    - sample_ready at phase==SPS-1, FIFO not empty: pop the next symbol into hold, phase<=0, stay in EMIT. No bubble between symbols.
    - sample_ready at phase==SPS-1, FIFO empty: go to IDLE, sample_valid=0 next cycle, underflow set.
- Latency: symbol pushed at edge t, first sample valid after edge t+1 (2-cycle latency into an empty block). No write-to-read bypass.
- Simultaneous push and pop: both take effect; fill_level unchanged.
- Push while full plus pop in the same cycle: push is still refused (sym_ready was 0).
- Pointers wrap modulo FIFO_DEPTH. Full/empty use an extra pointer MSB.
- Flags:
  - overflow and underflow stay set until clr_flags.
  - If clr_flags and a new set event occur in the same cycle, set wins.
- Phase counter width: clog2(SPS). No other arithmetic.

Decomposition:
- Shared package qam_pkg holds:
  - IQ_W=16, DATA_W=32.
  - FSM state enum (IDLE, EMIT).
  - A clog2 helper function.
- One natural sub-module: qam_sym_fifo. It is a synchronous single-clock FIFO with push/pop/full/empty/level, instanced once.
- FSM, phase counter and flags stay in the top.

Test Plan:
- Reset, SPS=8, ZERO_STUFF=0, push 0x1234ABCD once, sample_ready=1 -> after 2 cycles 8 consecutive samples of 0x1234ABCD, then sample_valid=0, underflow=1.
- ZERO_STUFF=1, push 0x00010002 -> samples 0x00010002, then 7 zeros, valid high for 8 cycles.
- Back-to-back: push 3 symbols A,B,C with sample_ready=1 -> 24 contiguous valid samples (8×A, 8×B, 8×C), no gap; underflow set only after C.
- Backpressure: sample_ready toggles 1,0,0,1... -> sample_out is stable while stalled and each symbol is still emitted exactly 8 times.
- Fill to 16 with sample_ready=0 -> sym_ready=0, fill_level=16. A 17th sym_valid -> overflow=1 and that symbol is never emitted. clr_flags -> overflow=0.
- Assert rst mid-burst at phase 3 with fill_level=5 -> next cycle sample_valid=0, fill_level=0, flags 0. The next push restarts at phase 0.
